// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - SIMPLEZ opcodes, sequencer states and decode helpers
package simplez_pkg;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPER   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Opcodes that need a second memory access on the CD field
    function automatic logic is_mem_op(input logic [2:0] co);
        return (co == OP_ST) || (co == OP_LD) || (co == OP_ADD);
    endfunction

endpackage

// File: rtl/simplez_alu.sv
// rtl/simplez_alu.sv - next-accumulator value and zero flag for SIMPLEZ
module simplez_alu
    import simplez_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic [2:0]    i_op,
    input  logic [DW-1:0] i_ac,
    input  logic [DW-1:0] i_rdata,
    output logic [DW-1:0] o_ac_next,
    output logic          o_zero
);

    always_comb begin
        o_ac_next = i_ac;
        case (i_op)
            OP_LD:   o_ac_next = i_rdata;
            OP_ADD:  o_ac_next = i_ac + i_rdata;
            OP_CLR:  o_ac_next = '0;
            OP_DEC:  o_ac_next = i_ac - DW'(1);
            default: o_ac_next = i_ac;
        endcase
    end

    assign o_zero = (i_ac == '0);

endmodule

// File: rtl/simplez_core.sv
// rtl/simplez_core.sv - SIMPLEZ datapath and sequencer on a ready/valid memory port
module simplez_core
    import simplez_pkg::*;
#(
    parameter int            AW       = 9,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int           DW       = AW + 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halted,
    output logic [DW-1:0] ac_out,
    output logic [AW-1:0] pc_out
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ri;
    logic [DW-1:0] r_ac;

    logic [2:0]    w_co;
    logic [AW-1:0] w_cd;
    logic [DW-1:0] w_ac_next;
    logic          w_ac_zero;
    logic          w_resume;

    assign w_co     = r_ri[DW-1:AW];
    assign w_cd     = r_ri[AW-1:0];
    assign w_resume = run;

    // One ALU serves both phases: CLR/DEC in DECODE, LD/ADD in OPER on mem_rdata
    simplez_alu #(.DW(DW)) u_alu (
        .i_op      (w_co),
        .i_ac      (r_ac),
        .i_rdata   (mem_rdata),
        .o_ac_next (w_ac_next),
        .o_zero    (w_ac_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus outputs decode from state/RI only; mem_ready steers next state alone
    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = r_pc;
        halted      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_co == OP_HALT)     w_state_nxt = S_HALT;
                else if (is_mem_op(w_co)) w_state_nxt = S_OPER;
                else                     w_state_nxt = w_resume ? S_FETCH : S_IDLE;
            end
            S_OPER: begin
                mem_addr = w_cd;
                mem_wr   = (w_co == OP_ST);
                mem_rd   = (w_co != OP_ST);
                if (mem_ready) w_state_nxt = w_resume ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
            r_ri <= '0;
            r_ac <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ri <= mem_rdata;
                        r_pc <= r_pc + AW'(1);
                    end
                end
                S_DECODE: begin
                    case (w_co)
                        OP_BR:          r_pc <= w_cd;
                        OP_BZ:          if (w_ac_zero) r_pc <= w_cd;
                        OP_CLR, OP_DEC: r_ac <= w_ac_next;
                        default: ;
                    endcase
                end
                S_OPER: begin
                    if (mem_ready && (w_co != OP_ST)) r_ac <= w_ac_next;
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = r_ac;
    assign ac_out    = r_ac;
    assign pc_out    = r_pc;

endmodule

// File: tb/tb_simplez_core.sv
// tb/tb_simplez_core.sv - scoreboard bench for simplez_core with a wait-state memory model
module tb_simplez_core;

    localparam int AW = 9;
    localparam int DW = 12;
    localparam int K_PC = 0, K_AC = 1, K_HALT = 2, K_RD = 3, K_WR = 4, K_MEM = 5, K_VAL = 6, K_TXQ = 7;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        string         name;
        int            kind;
        int            arg;
        logic [DW-1:0] exp;
    } probe_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          run;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          halted;
    logic [DW-1:0] ac_out;
    logic [AW-1:0] pc_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] img [0:(1<<AW)-1];
    int            load_seq = 0;
    int            load_seen = 0;
    logic [1:0]    stall_mode;
    txn_t          exp_q[$];
    probe_t        probe_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    logic          prev_req;
    logic          prev_ready;
    logic [31:0]   prev_bus;
    int            wait_left = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    simplez_core #(.AW(AW), .RESET_PC(9'd0)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .ac_out    (ac_out),
        .pc_out    (pc_out)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory model, ready generator and monitor share one negedge process
    always @(negedge clk) begin
        probe_t      p;
        txn_t        t;
        logic [31:0] act;
        logic [31:0] bus;
        logic        req;
        if (load_seq != load_seen) begin
            mem = img;
            load_seen = load_seq;
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.kind)
                K_PC:    act = 32'(pc_out);
                K_AC:    act = 32'(ac_out);
                K_HALT:  act = 32'(halted);
                K_RD:    act = 32'(mem_rd);
                K_WR:    act = 32'(mem_wr);
                K_MEM:   act = 32'(mem[p.arg]);
                K_VAL:   act = 32'(p.arg);
                default: act = 32'(exp_q.size());
            endcase
            cmp(p.name, act, 32'(p.exp));
        end
        req = mem_rd | mem_wr;
        bus = {pc_out, mem_rd, mem_wr, mem_addr, mem_wdata};
        if (req === 1'b1 && (prev_req !== 1'b1 || prev_ready === 1'b1)) begin
            wait_left = ((stall_mode[0] && mem_rd && mem_addr == '0) ||
                         (stall_mode[1] && mem_wr)) ? 3 : 0;
        end
        if (req === 1'b1 && prev_req === 1'b1 && prev_ready === 1'b0)
            cmp("wait_stable", bus, prev_bus);
        mem_ready = (wait_left == 0);
        if (wait_left > 0) wait_left--;
        if (req === 1'b1 && mem_ready && rstn === 1'b1) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_access", {23'd1, mem_addr}, 32'd0);
            end else begin
                t = exp_q.pop_front();
                cmp("access_kind", {30'd0, mem_rd, mem_wr}, t.wr ? 32'd1 : 32'd2);
                cmp("access_addr", 32'(mem_addr), 32'(t.addr));
                if (t.wr) cmp("write_data", 32'(mem_wdata), 32'(t.data));
            end
            if (mem_wr) mem[mem_addr] = mem_wdata;
        end
        prev_req   = req;
        prev_ready = mem_ready;
        prev_bus   = bus;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input string name, input int kind, input logic [DW-1:0] exp, input int arg = 0);
        probe_q.push_back('{name, kind, arg, exp});
    endtask

    task automatic expect_rd(input logic [AW-1:0] a);
        exp_q.push_back('{1'b0, a, '0});
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = '0;
    endtask

    task automatic commit();
        load_seq++;
        tick(1);
    endtask

    task automatic do_reset();
        run  = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    // Cycle count includes the edge on which IDLE first sees run=1
    task automatic wait_halt(input string name, input int exp_cycles);
        int c = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (halted === 1'b1) begin
                c = i;
                break;
            end
        end
        probe(name, K_VAL, DW'(exp_cycles), c);
    endtask

    initial begin
        rstn = 1'b0;
        run  = 1'b0;
        stall_mode = 2'b00;
        tick(2);
        probe("reset_pc", K_PC, 12'h000);
        probe("reset_ac", K_AC, 12'h000);
        probe("reset_rd", K_RD, 12'h000);
        probe("reset_wr", K_WR, 12'h000);
        probe("reset_halted", K_HALT, 12'h000);
        rstn = 1'b1;
        tick(1);

        // LD/ADD/ST/HALT
        clear_img();
        img[0] = 12'h20A; img[1] = 12'h40B; img[2] = 12'h00C; img[3] = 12'hE00;
        img[10] = 12'h005; img[11] = 12'h007;
        commit();
        expect_rd(9'd0); expect_rd(9'd10); expect_rd(9'd1); expect_rd(9'd11);
        expect_rd(9'd2); expect_wr(9'd12, 12'h00C); expect_rd(9'd3);
        run = 1'b1;
        wait_halt("prog1_halt_cycles", 12);
        probe("prog1_pc", K_PC, 12'h004);
        probe("prog1_ac", K_AC, 12'h00C);
        probe("prog1_mem12", K_MEM, 12'h00C, 12);
        probe("prog1_halted", K_HALT, 12'h001);
        probe("prog1_drained", K_TXQ, 12'h000);
        tick(1);
        do_reset();

        // CLR, DEC, BZ not taken, HALT
        clear_img();
        img[0] = 12'hA00; img[1] = 12'hC00; img[2] = 12'h850; img[3] = 12'hE00; img[12'h50] = 12'hE00;
        commit();
        expect_rd(9'd0); expect_rd(9'd1); expect_rd(9'd2); expect_rd(9'd3);
        run = 1'b1;
        wait_halt("bz_nt_halt_cycles", 9);
        probe("bz_nt_ac", K_AC, 12'hFFF);
        probe("bz_nt_pc", K_PC, 12'h004);
        probe("bz_nt_drained", K_TXQ, 12'h000);
        tick(1);
        do_reset();

        // CLR then BZ taken
        clear_img();
        img[0] = 12'hA00; img[1] = 12'h850; img[2] = 12'hE00; img[12'h50] = 12'hE00;
        commit();
        expect_rd(9'd0); expect_rd(9'd1); expect_rd(9'h050);
        run = 1'b1;
        wait_halt("bz_t_halt_cycles", 7);
        probe("bz_t_pc", K_PC, 12'h051);
        probe("bz_t_ac", K_AC, 12'h000);
        probe("bz_t_drained", K_TXQ, 12'h000);
        tick(1);
        do_reset();

        // Three wait states on the first fetch and on the store
        clear_img();
        img[0] = 12'h20A; img[1] = 12'h00C; img[2] = 12'hE00; img[10] = 12'h123;
        commit();
        stall_mode = 2'b11;
        expect_rd(9'd0); expect_rd(9'd10); expect_rd(9'd1); expect_wr(9'd12, 12'h123); expect_rd(9'd2);
        run = 1'b1;
        wait_halt("wait_halt_cycles", 15);
        probe("wait_pc", K_PC, 12'h003);
        probe("wait_mem12", K_MEM, 12'h123, 12);
        probe("wait_drained", K_TXQ, 12'h000);
        tick(1);
        stall_mode = 2'b00;
        do_reset();

        // BZ/DEC/BR into the top of memory, ADD wraps AC, PC wraps to 0
        clear_img();
        img[0] = 12'h9FC; img[1] = 12'hE00;
        img[9'h1FC] = 12'hC00; img[9'h1FD] = 12'h7FF; img[9'h1FE] = 12'hE00; img[9'h1FF] = 12'h410;
        img[12'h10] = 12'h002;
        commit();
        expect_rd(9'd0); expect_rd(9'h1FC); expect_rd(9'h1FD); expect_rd(9'h1FF);
        expect_rd(9'h010); expect_rd(9'd0); expect_rd(9'd1);
        run = 1'b1;
        wait_halt("wrap_halt_cycles", 14);
        probe("wrap_ac", K_AC, 12'h001);
        probe("wrap_pc", K_PC, 12'h002);
        probe("wrap_drained", K_TXQ, 12'h000);
        tick(1);
        do_reset();

        // run dropped during OPER of LD, then resumed
        clear_img();
        img[0] = 12'h20A; img[1] = 12'hE00; img[10] = 12'h055;
        commit();
        expect_rd(9'd0); expect_rd(9'd10);
        run = 1'b1;
        tick(3);
        run = 1'b0;
        tick(3);
        probe("stop_rd", K_RD, 12'h000);
        probe("stop_pc", K_PC, 12'h001);
        probe("stop_ac", K_AC, 12'h055);
        probe("stop_halted", K_HALT, 12'h000);
        tick(1);
        expect_rd(9'd1);
        run = 1'b1;
        wait_halt("resume_halt_cycles", 3);
        probe("resume_pc", K_PC, 12'h002);
        probe("resume_drained", K_TXQ, 12'h000);
        tick(1);
        do_reset();

        // Reset while a store is waiting
        clear_img();
        img[0] = 12'h00C; img[1] = 12'hE00;
        commit();
        stall_mode = 2'b10;
        expect_rd(9'd0);
        run = 1'b1;
        tick(4);
        probe("st_wait_wr", K_WR, 12'h001);
        rstn = 1'b0;
        run  = 1'b0;
        tick(1);
        probe("rst_wr_drop", K_WR, 12'h000);
        probe("rst_pc", K_PC, 12'h000);
        probe("rst_mem12", K_MEM, 12'h000, 12);
        rstn = 1'b1;
        stall_mode = 2'b00;
        tick(1);
        probe("rst_drained", K_TXQ, 12'h000);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
